// File: rtl/fc_result_writer.sv
// fc_result_writer
// Write-back mover for the fully-connected datapath. Each accepted result pair
// goes through optional ReLU and signed saturation to DWIDTH/2 bits per lane.
// The two lanes are packed {lane0, lane1} and written to consecutive BRAM
// addresses starting at a captured base address. One register stage separates
// acceptance from the BRAM write.
//
// Ports
//   clk, reset_n              clock, async active-low reset
//   i_run                     start pulse (honoured only in IDLE)
//   i_num_cnt                 words to write (captured on accepted i_run)
//   i_base_addr               first write address (captured on accepted i_run)
//   i_relu_en                 ReLU enable (captured on accepted i_run)
//   i_valid                   result pair strobe
//   i_result_0, i_result_1    signed core results, lane 0 / lane 1
//   addr_b, ce_b, we_b, d_b   BRAM write port
//   o_idle, o_running, o_done FSM status (o_done is a one-cycle pulse)
//   o_overflow                sticky: a valid arrived that could not be accepted
//   o_sat                     sticky: at least one lane was clipped
module fc_result_writer #(
    parameter int unsigned CNT_BIT   = 31,
    parameter int unsigned DWIDTH    = 32,
    parameter int unsigned AWIDTH    = 12,
    parameter int unsigned RES_WIDTH = 64
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        i_run,
    input  logic [CNT_BIT-1:0]          i_num_cnt,
    input  logic [AWIDTH-1:0]           i_base_addr,
    input  logic                        i_relu_en,
    input  logic                        i_valid,
    input  logic signed [RES_WIDTH-1:0] i_result_0,
    input  logic signed [RES_WIDTH-1:0] i_result_1,
    output logic [AWIDTH-1:0]           addr_b,
    output logic                        ce_b,
    output logic                        we_b,
    output logic [DWIDTH-1:0]           d_b,
    output logic                        o_idle,
    output logic                        o_running,
    output logic                        o_done,
    output logic                        o_overflow,
    output logic                        o_sat
);

    localparam int unsigned LW = DWIDTH / 2;

    localparam logic signed [RES_WIDTH-1:0] SAT_MAX =
        (RES_WIDTH'(1) <<< (LW - 1)) - RES_WIDTH'(1);
    // Two's complement: ~max is the most negative lane value.
    localparam logic signed [RES_WIDTH-1:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_t;

    state_t              r_state;
    logic [CNT_BIT-1:0]  r_num_cnt;
    logic [CNT_BIT-1:0]  r_acc_cnt;
    logic [CNT_BIT-1:0]  r_wr_cnt;
    logic [AWIDTH-1:0]   r_base;
    logic                r_relu_en;
    logic [AWIDTH-1:0]   r_addr;
    logic [DWIDTH-1:0]   r_data;
    logic                r_we;
    logic                r_idle;
    logic                r_running;
    logic                r_done;
    logic                r_overflow;
    logic                r_sat;

    logic                w_accept;
    logic                w_last_write;
    logic [LW:0]         w_lane0;
    logic [LW:0]         w_lane1;

    // Returns {clipped, lane value}.
    function automatic logic [LW:0] proc_lane(input logic signed [RES_WIDTH-1:0] v,
                                              input logic relu);
        logic signed [RES_WIDTH-1:0] t;
        t = (relu && v[RES_WIDTH-1]) ? '0 : v;
        if (t > SAT_MAX) begin
            return {1'b1, SAT_MAX[LW-1:0]};
        end else if (t < SAT_MIN) begin
            return {1'b1, SAT_MIN[LW-1:0]};
        end else begin
            return {1'b0, t[LW-1:0]};
        end
    endfunction

    always_comb begin
        w_accept = (r_state == StRun) && i_valid && (r_acc_cnt < r_num_cnt);
        // wr_cnt advances on acceptance, so during the final write it equals num_cnt.
        w_last_write = (r_state == StRun) && r_we && (r_wr_cnt == r_num_cnt);
        w_lane0 = proc_lane(i_result_0, r_relu_en);
        w_lane1 = proc_lane(i_result_1, r_relu_en);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= StIdle;
            r_num_cnt  <= '0;
            r_acc_cnt  <= '0;
            r_wr_cnt   <= '0;
            r_base     <= '0;
            r_relu_en  <= 1'b0;
            r_addr     <= '0;
            r_data     <= '0;
            r_we       <= 1'b0;
            r_idle     <= 1'b1;
            r_running  <= 1'b0;
            r_done     <= 1'b0;
            r_overflow <= 1'b0;
            r_sat      <= 1'b0;
        end else begin
            r_we   <= 1'b0;
            r_done <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (i_run) begin
                        r_num_cnt  <= i_num_cnt;
                        r_base     <= i_base_addr;
                        r_relu_en  <= i_relu_en;
                        r_overflow <= 1'b0;
                        r_sat      <= 1'b0;
                        r_idle     <= 1'b0;
                        if (i_num_cnt == '0) begin
                            r_state <= StDone;
                            r_done  <= 1'b1;
                        end else begin
                            r_state   <= StRun;
                            r_running <= 1'b1;
                        end
                    end
                end
                StRun: begin
                    if (w_accept) begin
                        r_data    <= {w_lane0[LW-1:0], w_lane1[LW-1:0]};
                        r_addr    <= r_base + r_wr_cnt[AWIDTH-1:0];
                        r_we      <= 1'b1;
                        r_acc_cnt <= r_acc_cnt + CNT_BIT'(1);
                        r_wr_cnt  <= r_wr_cnt + CNT_BIT'(1);
                        r_sat     <= r_sat | w_lane0[LW] | w_lane1[LW];
                    end
                    if (w_last_write) begin
                        r_state   <= StDone;
                        r_running <= 1'b0;
                        r_done    <= 1'b1;
                    end
                end
                StDone: begin
                    r_state   <= StIdle;
                    r_idle    <= 1'b1;
                    r_acc_cnt <= '0;
                    r_wr_cnt  <= '0;
                end
                default: begin
                    r_state   <= StIdle;
                    r_idle    <= 1'b1;
                    r_running <= 1'b0;
                end
            endcase
            // A dropped pair is flagged even on the cycle a new run is accepted.
            if (i_valid && !w_accept) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign addr_b     = r_addr;
    assign ce_b       = r_we;
    assign we_b       = r_we;
    assign d_b        = r_data;
    assign o_idle     = r_idle;
    assign o_running  = r_running;
    assign o_done     = r_done;
    assign o_overflow = r_overflow;
    assign o_sat      = r_sat;

endmodule

// File: tb/tb_fc_result_writer.sv
module tb_fc_result_writer;

    logic               clk;
    logic               reset_n;
    logic               i_run;
    logic [30:0]        i_num_cnt;
    logic [11:0]        i_base_addr;
    logic               i_relu_en;
    logic               i_valid;
    logic signed [63:0] i_result_0;
    logic signed [63:0] i_result_1;
    logic [11:0]        addr_b;
    logic               ce_b;
    logic               we_b;
    logic [31:0]        d_b;
    logic               o_idle;
    logic               o_running;
    logic               o_done;
    logic               o_overflow;
    logic               o_sat;

    int n_cmp = 0;
    int n_err = 0;
    int n_writes = 0;
    int w0;

    fc_result_writer #(
        .CNT_BIT  (31),
        .DWIDTH   (32),
        .AWIDTH   (12),
        .RES_WIDTH(64)
    ) u_dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_run      (i_run),
        .i_num_cnt  (i_num_cnt),
        .i_base_addr(i_base_addr),
        .i_relu_en  (i_relu_en),
        .i_valid    (i_valid),
        .i_result_0 (i_result_0),
        .i_result_1 (i_result_1),
        .addr_b     (addr_b),
        .ce_b       (ce_b),
        .we_b       (we_b),
        .d_b        (d_b),
        .o_idle     (o_idle),
        .o_running  (o_running),
        .o_done     (o_done),
        .o_overflow (o_overflow),
        .o_sat      (o_sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (we_b === 1'b1) n_writes++;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_run(input logic [30:0] num, input logic [11:0] base, input logic relu);
        i_run       = 1'b1;
        i_num_cnt   = num;
        i_base_addr = base;
        i_relu_en   = relu;
        tick();
        i_run = 1'b0;
    endtask

    task automatic pair(input logic signed [63:0] a, input logic signed [63:0] b);
        i_valid    = 1'b1;
        i_result_0 = a;
        i_result_1 = b;
    endtask

    // Write cycle just ended: expect DONE pulse, then IDLE.
    task automatic finish_run(input string tag);
        tick();
        check({tag, "_done"}, 64'(o_done), 64'd1);
        check({tag, "_done_we"}, 64'(we_b), 64'd0);
        tick();
        check({tag, "_idle"}, 64'(o_idle), 64'd1);
        check({tag, "_done_pulse"}, 64'(o_done), 64'd0);
    endtask

    initial begin
        reset_n     = 1'b0;
        i_run       = 1'b0;
        i_num_cnt   = '0;
        i_base_addr = '0;
        i_relu_en   = 1'b0;
        i_valid     = 1'b0;
        i_result_0  = '0;
        i_result_1  = '0;
        tick();
        tick();
        check("rst_idle", 64'(o_idle), 64'd1);
        check("rst_run", 64'(o_running), 64'd0);
        check("rst_done", 64'(o_done), 64'd0);
        check("rst_ovf", 64'(o_overflow), 64'd0);
        check("rst_sat", 64'(o_sat), 64'd0);
        check("rst_we", 64'({ce_b, we_b}), 64'd0);
        check("rst_addr", 64'(addr_b), 64'd0);
        check("rst_data", 64'(d_b), 64'd0);
        reset_n = 1'b1;
        tick();

        // Basic run
        do_run(31'd3, 12'h010, 1'b0);
        check("b_running", 64'(o_running), 64'd1);
        check("b_no_we", 64'(we_b), 64'd0);
        pair(64'sd1, 64'sd2);
        tick();
        check("b_we0", 64'({ce_b, we_b}), 64'd3);
        check("b_addr0", 64'(addr_b), 64'h010);
        check("b_d0", 64'(d_b), 64'h0001_0002);
        pair(-64'sd1, 64'sd5);
        tick();
        check("b_addr1", 64'(addr_b), 64'h011);
        check("b_d1", 64'(d_b), 64'hFFFF_0005);
        pair(64'sd100, -64'sd100);
        tick();
        check("b_addr2", 64'(addr_b), 64'h012);
        check("b_d2", 64'(d_b), 64'h0064_FF9C);
        i_valid = 1'b0;
        finish_run("b");
        check("b_sat", 64'(o_sat), 64'd0);
        check("b_ovf", 64'(o_overflow), 64'd0);
        check("b_hold_addr", 64'(addr_b), 64'h012);
        check("b_hold_data", 64'(d_b), 64'h0064_FF9C);

        // Saturation, ReLU off
        do_run(31'd1, 12'h000, 1'b0);
        pair(64'sd70000, -64'sd70000);
        tick();
        check("s_d", 64'(d_b), 64'h7FFF_8000);
        check("s_sat", 64'(o_sat), 64'd1);
        i_valid = 1'b0;
        finish_run("s");
        check("s_sat_hold", 64'(o_sat), 64'd1);

        // ReLU on; new run clears sat first
        do_run(31'd1, 12'h005, 1'b1);
        check("r_sat_clr", 64'(o_sat), 64'd0);
        pair(-64'sd5, 64'sd70000);
        tick();
        check("r_addr", 64'(addr_b), 64'h005);
        check("r_d", 64'(d_b), 64'h0000_7FFF);
        check("r_sat", 64'(o_sat), 64'd1);
        i_valid = 1'b0;
        finish_run("r");

        // Gapped valids with address wrap
        do_run(31'd4, 12'hFFE, 1'b0);
        for (int k = 0; k < 4; k++) begin
            pair(64'(k), 64'(k + 16));
            tick();
            i_valid = 1'b0;
            check($sformatf("g_we%0d", k), 64'(we_b), 64'd1);
            check($sformatf("g_addr%0d", k), 64'(addr_b), 64'((12'hFFE + 12'(k)) & 12'hFFF));
            check($sformatf("g_d%0d", k), 64'(d_b), {32'd0, 16'(k), 16'(k + 16)});
            if (k < 3) begin
                tick();
                check($sformatf("g_gap_a%0d", k), 64'(we_b), 64'd0);
                tick();
                check($sformatf("g_gap_b%0d", k), 64'(we_b), 64'd0);
                check($sformatf("g_run%0d", k), 64'(o_running), 64'd1);
            end
        end
        finish_run("g");

        // Zero count
        w0 = n_writes;
        do_run(31'd0, 12'h123, 1'b0);
        check("z_done", 64'(o_done), 64'd1);
        check("z_we", 64'(we_b), 64'd0);
        tick();
        check("z_idle", 64'(o_idle), 64'd1);
        check("z_nowrites", 64'(n_writes - w0), 64'd0);

        // i_run re-asserted in RUN is ignored
        do_run(31'd2, 12'h100, 1'b0);
        i_run       = 1'b1;
        i_num_cnt   = 31'd5;
        i_base_addr = 12'h200;
        tick();
        i_run = 1'b0;
        check("i_running", 64'(o_running), 64'd1);
        pair(64'sd3, 64'sd4);
        tick();
        check("i_addr0", 64'(addr_b), 64'h100);
        tick();
        check("i_addr1", 64'(addr_b), 64'h101);
        i_valid = 1'b0;
        finish_run("i");

        // Overflow: count 2, three valids
        w0 = n_writes;
        do_run(31'd2, 12'h020, 1'b0);
        pair(64'sd1, 64'sd1);
        tick();
        check("o_addr0", 64'(addr_b), 64'h020);
        tick();
        check("o_addr1", 64'(addr_b), 64'h021);
        check("o_ovf_pre", 64'(o_overflow), 64'd0);
        tick();
        i_valid = 1'b0;
        check("o_third_we", 64'(we_b), 64'd0);
        check("o_ovf_set", 64'(o_overflow), 64'd1);
        check("o_done", 64'(o_done), 64'd1);
        tick();
        check("o_idle", 64'(o_idle), 64'd1);
        check("o_ovf_hold", 64'(o_overflow), 64'd1);
        check("o_writes", 64'(n_writes - w0), 64'd2);
        do_run(31'd1, 12'h030, 1'b0);
        check("o_ovf_clr", 64'(o_overflow), 64'd0);
        pair(64'sd7, 64'sd8);
        tick();
        i_valid = 1'b0;
        finish_run("o2");

        // Reset mid-run after 1 of 4 writes
        w0 = n_writes;
        do_run(31'd4, 12'h040, 1'b0);
        pair(64'sd9, 64'sd9);
        tick();
        check("m_addr0", 64'(addr_b), 64'h040);
        i_valid = 1'b0;
        tick();
        reset_n = 1'b0;
        #1;
        check("m_idle", 64'(o_idle), 64'd1);
        check("m_run", 64'(o_running), 64'd0);
        check("m_we", 64'({ce_b, we_b}), 64'd0);
        check("m_addr", 64'(addr_b), 64'd0);
        check("m_data", 64'(d_b), 64'd0);
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        tick();
        check("m_writes", 64'(n_writes - w0), 64'd1);
        do_run(31'd1, 12'h300, 1'b0);
        pair(64'sd2, -64'sd2);
        tick();
        i_valid = 1'b0;
        check("m_new_addr", 64'(addr_b), 64'h300);
        check("m_new_d", 64'(d_b), 64'h0002_FFFE);
        finish_run("m");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fc_result_writer.md
# fc_result_writer

Write-back data mover for the fully-connected datapath. It accepts per-element results from two fully-connected cores and applies optional ReLU and signed saturation to each lane. It packs the two lanes into one DWIDTH word and writes the words sequentially into a result BRAM, starting at a programmable base address. It runs alongside the BRAM-read data mover: the same `i_run` starts both, and this block reports `o_done` once the last result word is committed to memory.

## Interface
Parameters:
- `CNT_BIT`, 31: width of the element count.
- `DWIDTH`, 32: BRAM data width. Each lane is DWIDTH/2 = 16 bits.
- `AWIDTH`, 12: BRAM address width.
- `RES_WIDTH`, 64: signed width of each core result.

Ports:
- `clk`  in  1  sole clock. One clock; every register is on its rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `i_run`  in  1  start pulse. Sampled only in IDLE.
- `i_num_cnt`  in  CNT_BIT  number of words to write. Captured on an accepted `i_run`.
- `i_base_addr`  in  AWIDTH  first write address. Captured on an accepted `i_run`.
- `i_relu_en`  in  1  ReLU enable. Captured on an accepted `i_run`.
- `i_valid`  in  1  strobe marking a valid result pair.
- `i_result_0`  in  RES_WIDTH  signed lane 0 result.
- `i_result_1`  in  RES_WIDTH  signed lane 1 result.
- `addr_b`  out  AWIDTH  BRAM address.
- `ce_b`  out  1  BRAM chip enable.
- `we_b`  out  1  BRAM write enable.
- `d_b`  out  DWIDTH  BRAM write data.
- `o_idle`  out  1  high in IDLE.
- `o_running`  out  1  high in RUN.
- `o_done`  out  1  high for exactly one cycle, in DONE.
- `o_overflow`  out  1  sticky error flag. Cleared on the next accepted `i_run`.
- `o_sat`  out  1  sticky flag: at least one lane has saturated. Cleared on the next accepted `i_run`.

## Operation
- FSM states are IDLE, RUN and DONE. Transitions:
  - IDLE to RUN on `i_run`, when `i_num_cnt` != 0.
  - IDLE to DONE on `i_run`, when `i_num_cnt` == 0. No write occurs.
  - RUN to DONE in the cycle after the write of word num_cnt-1.
  - DONE to IDLE unconditionally.
- `i_run` outside IDLE is ignored. The captured count, base address and ReLU enable do not change.
- Accept rule: `i_valid` is accepted only while in RUN and while acc_cnt < num_cnt. Each acceptance increments acc_cnt.
- Lane processing, per lane:
  - If ReLU is enabled and the value is negative, the value becomes 0.
  - The value is then saturated to the signed 16-bit range: values > 32767 become 0x7FFF, and values < -32768 become 0x8000.
  - Any clipping sets `o_sat`.
- Packing: `d_b` = {lane0[15:0], lane1[15:0]}, with lane 0 in the upper half.
- Write stage (one register stage):
  - An accepted pair is registered.
  - In the next cycle `ce_b` = `we_b` = 1, `addr_b` = (base + wr_cnt) mod 2^AWIDTH, and wr_cnt increments.
- Address wrap: past 2^AWIDTH-1 the address wraps to 0 silently. This is not an error.
- `o_overflow` is set when `i_valid` = 1 and the beak is not accepted, i.e. in IDLE or DONE, or in RUN with acc_cnt == num_cnt. The pair is dropped and nothing is written.
- Both counters clear when the block enters IDLE.

## Timing
- Reset values:
  - State IDLE, so `o_idle` = 1.
  - `o_running`, `o_done`, `o_overflow`, `o_sat`, `ce_b`, `we_b` = 0.
  - `addr_b`, `d_b` = 0.
  - All counters and captured registers = 0.
- Latency: `i_valid` at cycle t produces the BRAM write at cycle t+1.
- Back-to-back valids give one write per cycle, with no bubbles.
- Completion sequence:
  - Last write at cycle t.
  - `o_done` = 1 at t+1.
  - `o_idle` = 1 at t+2.
  - A new `i_run` is accepted at t+2 at the earliest.
- Zero count: `i_run` at t gives `o_done` at t+1.
- `ce_b` and `we_b` are never high outside the write cycle. `addr_b` and `d_b` hold their last values when idle.
- Reset asserted mid-operation: the state returns to IDLE immediately (asynchronously). `we_b` drops and no partial write is issued.

## Test plan
- Basic run:
  - Stimulus: base 0x010, count 3, ReLU off; pairs (1,2), (-1,5), (100,-100) on consecutive cycles.
  - Required: writes 0x00010002 @0x010, 0xFFFF0005 @0x011, 0x0064FF9C @0x012; `o_done` one cycle after the last write; `o_sat` = 0.
- Saturation and ReLU:
  - Stimulus: ReLU off, pair (70000, -70000).
  - Required: 0x7FFF8000 and `o_sat` = 1.
  - Stimulus: ReLU on, pair (-5, 70000).
  - Required: 0x00007FFF.
- Gapped valid and wrap:
  - Stimulus: base 0xFFE, count 4, valids separated by 2 idle cycles.
  - Required: addresses 0xFFE, 0xFFF, 0x000, 0x001; each write exactly one cycle after its valid.
- Zero count and ignored run:
  - Stimulus: `i_run` with count 0.
  - Required: `o_done` on the next cycle, no `we_b`.
  - Stimulus: `i_run` re-asserted in RUN.
  - Required: no effect on count or address.
- Overflow:
  - Stimulus: count 2, 3 valids.
  - Required: only 2 writes; `o_overflow` = 1 and held until the next `i_run`, which clears it.
- Reset mid-run:
  - Stimulus: `reset_n` low after 1 of 4 writes.
  - Required: all outputs at reset values, no further writes.
  - Stimulus: a new run after reset.
  - Required: writes start at the new base.
